// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetches an instruction word (and an optional immediate word from the
// following address) from instruction memory, holds it while it executes, and then selects the
// next pc from the decoded control supplied by the control unit.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   imem_req/imem_addr    instruction-memory read request and address
//   imem_ack/imem_rdata   read data valid strobe and read data
//   opcode, instruction   registered current instruction (opcode is the top 6 bits)
//   immediate             registered immediate word, 0 when the instruction has none
//   instr_valid           high while the current instruction is in its execute cycle(s)
//   pc_increment_control, pc_control, branch, zero_flag, return_address
//                         control-unit decode and datapath inputs used to pick next pc
//   stall                 holds the execute stage
//   pc, pc_return         current instruction address, and pc + instruction length
module fetch_unit #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [5:0]            opcode,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic [DATA_WIDTH-1:0] immediate,
  output logic                  instr_valid,
  input  logic                  pc_increment_control,
  input  logic [1:0]            pc_control,
  input  logic                  branch,
  input  logic                  zero_flag,
  input  logic [ADDR_WIDTH-1:0] return_address,
  input  logic                  stall,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_return
);

  typedef enum logic [1:0] {StIdle, StFetchInstr, StFetchImm, StExecute} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  // Set in the cycle after an ack: the request drops and the control unit gets one cycle to
  // decode the freshly latched opcode before the FSM moves on.
  logic                  got_q, got_d;

  logic                  needs_imm;
  logic [ADDR_WIDTH-1:0] pc_plus1;
  logic [ADDR_WIDTH-1:0] pc_len;
  logic [ADDR_WIDTH-1:0] next_pc;

  assign needs_imm = pc_increment_control | (pc_control == 2'b01);
  assign pc_plus1  = pc_q + ADDR_WIDTH'(1);
  assign pc_len    = needs_imm ? (pc_q + ADDR_WIDTH'(2)) : pc_plus1;

  always_comb begin
    next_pc = pc_len;
    case (pc_control)
      2'b01:   next_pc = imm_q[ADDR_WIDTH-1:0];
      2'b10:   next_pc = return_address;
      2'b00:   if (branch && zero_flag) next_pc = imm_q[ADDR_WIDTH-1:0];
      default: next_pc = pc_len;  // 11 is reserved: fall through to sequential
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    imm_d     = imm_q;
    got_d     = got_q;
    imem_req  = 1'b0;
    imem_addr = pc_q;
    case (state_q)
      StIdle: begin
        got_d   = 1'b0;
        state_d = StFetchInstr;
      end
      StFetchInstr: begin
        if (!got_q) begin
          imem_req = 1'b1;
          if (imem_ack) begin
            instr_d = imem_rdata;
            got_d   = 1'b1;
          end
        end else begin
          got_d = 1'b0;
          if (needs_imm) begin
            state_d = StFetchImm;
          end else begin
            imm_d   = '0;
            state_d = StExecute;
          end
        end
      end
      StFetchImm: begin
        imem_addr = pc_plus1;
        if (!got_q) begin
          imem_req = 1'b1;
          if (imem_ack) begin
            imm_d = imem_rdata;
            got_d = 1'b1;
          end
        end else begin
          got_d   = 1'b0;
          state_d = StExecute;
        end
      end
      StExecute: begin
        if (!stall) begin
          pc_d    = next_pc;
          state_d = StFetchInstr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      instr_q <= '0;
      imm_q   <= '0;
      got_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      imm_q   <= imm_d;
      got_q   <= got_d;
    end
  end

  assign opcode      = instr_q[DATA_WIDTH-1 -: 6];
  assign instruction = instr_q;
  assign immediate   = imm_q;
  assign instr_valid = (state_q == StExecute);
  assign pc          = pc_q;
  // Only meaningful during execute; forced to 0 otherwise so the idle/reset view is all zero.
  assign pc_return   = instr_valid ? pc_len : '0;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, sets the instruction-memory address and PC width.
REQ-002 Parameter DATA_WIDTH, default 16, sets the instruction word width; opcode is bits [DATA_WIDTH-1:DATA_WIDTH-6].
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  async active-high reset.
REQ-006 imem_req  output  1  instruction-memory read request.
REQ-007 imem_addr  output  ADDR_WIDTH  read address; stable while imem_req=1.
REQ-008 imem_ack  input  1  read data valid this cycle.
REQ-009 imem_rdata  input  DATA_WIDTH  read data.
REQ-010 opcode  output  6  registered opcode of current instruction, fed to control_unit.
REQ-011 instruction  output  DATA_WIDTH  registered current instruction word.
REQ-012 immediate  output  DATA_WIDTH  registered immediate word; 0 if none was fetched.
REQ-013 instr_valid  output  1  current instruction is executing.
REQ-014 pc_increment_control, pc_control[1:0], branch  input  1/2/1  decoded control from control_unit.
REQ-015 zero_flag  input  1  ALU zero flag for jz.
REQ-016 return_address  input  ADDR_WIDTH  popped stack value for return.
REQ-017 stall  input  1  holds execute stage.
REQ-018 pc  output  ADDR_WIDTH  address of current instruction.
REQ-019 pc_return  output  ADDR_WIDTH  pc + instruction length, pushed by call.

Function
REQ-020 The FSM SHALL have states IDLE, FETCH_INSTR, FETCH_IMM, EXECUTE.
REQ-021 IDLE SHALL go to FETCH_INSTR unconditionally on the next clock.
REQ-022 In FETCH_INSTR, imem_req=1 and imem_addr=pc; on imem_ack=1 the unit SHALL latch imem_rdata into instruction and opcode.
REQ-023 After the instruction is latched, the needs_imm condition SHALL be evaluated from the control-unit response to the new opcode; needs_imm = pc_increment_control=1 OR pc_control=01.
REQ-024 From FETCH_INSTR, the FSM SHALL advance on the cycle after the latch: to FETCH_IMM if needs_imm=1, else to EXECUTE with immediate cleared to 0.
REQ-025 In FETCH_IMM, imem_req=1 and imem_addr=pc+1 (mod 2^ADDR_WIDTH); on imem_ack=1 the unit SHALL latch immediate and go to EXECUTE.
REQ-026 imem_req SHALL be 0 in IDLE and EXECUTE, and in the cycle after each ack; imem_ack while imem_req=0 SHALL be ignored.
REQ-027 In EXECUTE, instr_valid SHALL be 1; with stall=1 the FSM, pc, and all registered outputs SHALL hold.
REQ-028 With stall=0 in EXECUTE, pc SHALL load next_pc and the FSM SHALL go to FETCH_INSTR, giving one execute cycle per instruction.
REQ-029 len SHALL be 2 if needs_imm, else 1; pc_return = pc + len mod 2^ADDR_WIDTH, valid while instr_valid=1.
REQ-030 next_pc SHALL be selected as follows:
  - pc_control=01: immediate[ADDR_WIDTH-1:0]
  - pc_control=10: return_address
  - pc_control=00 with branch=1 and zero_flag=1: immediate[ADDR_WIDTH-1:0]
  - otherwise, including pc_control=11 (reserved): pc_return
REQ-031 PC arithmetic SHALL wrap modulo 2^ADDR_WIDTH; at pc = 2^ADDR_WIDTH-1, the immediate SHALL be fetched from address 0.
REQ-032 Minimum latency with single-cycle ack: 3 cycles per instruction without an immediate, 5 with an immediate.

Reset
REQ-033 While reset=1, the unit SHALL force state=IDLE, pc=0, and imem_req=0, and SHALL zero opcode, instruction, immediate, and instr_valid.
REQ-034 Reset asserted mid-fetch or mid-stall SHALL abort immediately; an outstanding ack SHALL be discarded.
REQ-035 After reset release, the first request SHALL go to address 0.

Verification
REQ-036 Release reset, with memory returning opcode add (000010) at address 0 and ack in 1 cycle -> imem_addr=0, instr_valid pulses once, then pc=1 and a request goes to address 1.
REQ-037 Execute movi at pc=4 with immediate 0x00AB -> two requests (addresses 4 and 5), immediate=0x00AB, pc_return=6, next pc=6.
REQ-038 Execute jz at pc=10 targeting 0x20: with zero_flag=1 -> pc=0x20; with zero_flag=0 -> pc=12.
REQ-039 Execute call at pc=0x30 targeting 0x80 -> pc_return=0x32, next pc=0x80; then a return with return_address=0x32 -> pc=0x32.
REQ-040 Hold stall=1 for 3 cycles in EXECUTE, and separately delay ack 4 cycles -> instr_valid held high for 4 cycles with pc unchanged; imem_addr stable until ack.
REQ-041 Assert reset during FETCH_IMM at pc=0xFF -> all outputs zero; after release, first fetch at address 0; the wrap case fetches its immediate from address 0.
